// File: rtl/dcm_phase_shift_ctrl.sv
// Variable phase-shift sequencer for the 125 MHz DCM, clocked on PSCLK (33 MHz).
// Takes a signed target offset and walks the DCM toward it one PSEN step at a
// time. It waits for PSDONE after each step, and stops early on DCM saturation
// (STATUS[0]) or on a missing PSDONE.
module dcm_phase_shift_ctrl #(
  parameter int POS_WIDTH = 9,
  parameter int MAX_POS   = 255,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk33_i,
  input  logic                 rst_i,
  input  logic [POS_WIDTH-1:0] target_i,
  input  logic                 go_i,
  output logic                 ps_en_o,
  output logic                 ps_incdec_o,
  input  logic                 psdone_i,
  input  logic                 pslimit_i,
  output logic [POS_WIDTH-1:0] current_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 limit_o,
  output logic                 timeout_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic signed [POS_WIDTH-1:0] POS_MAX = POS_WIDTH'(MAX_POS);
  localparam logic signed [POS_WIDTH-1:0] NEG_MAX = POS_WIDTH'(-MAX_POS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PULSE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                       state_q, state_d;
  logic signed [POS_WIDTH-1:0]  cur_q, cur_d;
  logic signed [POS_WIDTH-1:0]  tgt_q, tgt_d;
  logic                         ps_en_q, ps_en_d;
  logic                         incdec_q, incdec_d;
  logic                         done_q, done_d;
  logic                         limit_q, limit_d;
  logic                         timeout_q, timeout_d;
  logic [CW-1:0]                cnt_q, cnt_d;

  logic signed [POS_WIDTH-1:0]  target_s;
  logic signed [POS_WIDTH-1:0]  target_clamped;
  logic [CW-1:0]                cnt_inc;

  // Clamp the requested target into the symmetric range the DCM may be driven to.
  always_comb begin
    target_s = $signed(target_i);
    if (target_s > POS_MAX) begin
      target_clamped = POS_MAX;
    end else if (target_s < NEG_MAX) begin
      target_clamped = NEG_MAX;
    end else begin
      target_clamped = target_s;
    end
  end

  // Next-state and next-output logic. PSEN and done are registered, so each one
  // is raised on the transition into its state (PULSE or DONE) and lasts that
  // single cycle.
  // The wait counter is compared after incrementing. This lets the WAIT state
  // hold for at most TIMEOUT-1 cycles, so a timeout puts done_o exactly TIMEOUT
  // cycles after ps_en_o.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    ps_en_d   = 1'b0;
    incdec_d  = incdec_q;
    done_d    = 1'b0;
    limit_d   = limit_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    cnt_inc   = cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        if (go_i) begin
          tgt_d     = target_clamped;
          limit_d   = 1'b0;
          timeout_d = 1'b0;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cur_q == tgt_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          incdec_d = (tgt_q > cur_q);
          ps_en_d  = 1'b1;
          state_d  = S_PULSE;
        end
      end
      S_PULSE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (psdone_i) begin
          if (pslimit_i) begin
            limit_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cur_d   = incdec_q ? (cur_q + POS_WIDTH'(1)) : (cur_q - POS_WIDTH'(1));
            state_d = S_CHECK;
          end
        end else if (cnt_inc == CNT_LAST) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers. Reset matches the DCM reset (phase back to 0).
  always_ff @(posedge clk33_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      tgt_q     <= '0;
      ps_en_q   <= 1'b0;
      incdec_q  <= 1'b0;
      done_q    <= 1'b0;
      limit_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      ps_en_q   <= ps_en_d;
      incdec_q  <= incdec_d;
      done_q    <= done_d;
      limit_q   <= limit_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ps_en_o     = ps_en_q;
  assign ps_incdec_o = incdec_q;
  assign current_o   = cur_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign limit_o     = limit_q;
  assign timeout_o   = timeout_q;

endmodule
